// File: rtl/udp_tx_sched.sv
// udp_tx_sched - round-robin transmit scheduler for the UDP stack's TX user
// interface. NUM_CH payload sources share one UDP transmitter. One pending
// request is granted at a time. Its header fields are latched, its length is
// validated, and tx_start_en is issued. tx_req/tx_data are then routed to the
// granted source. An inter-packet gap is enforced after tx_done.
//
// Optional build macro: UDP_TX_SCHED_TIMEOUT_EN adds a BUSY watchdog that
// abandons a packet after TIMEOUT_CYCLES clocks without tx_done.
//
// Ports
//   gmii_tx_clk, rst         clock, synchronous active-high reset
//   ch_req                   per-channel level request, held until ch_ack
//   ch_byte_num/des_mac/ip   per-channel header fields (packed, channel i at slice i)
//   ch_data                  per-channel payload byte
//   ch_ack                   pulse: request consumed (accepted or rejected)
//   ch_rd_en                 tx_req forwarded to the granted channel
//   ch_done / ch_err         pulses for completion / rejection or timeout
//   tx_start_en              start pulse to the UDP transmitter
//   tx_byte_num/des_mac/ip   latched header of the granted packet
//   tx_data                  payload byte of the granted channel
//   tx_req, tx_done          byte request / packet complete from transmitter
//   busy, grant_id           scheduler activity, current or last grant
//
// state | meaning
// IDLE  | waiting for any ch_req; picks next channel from rr_ptr and latches header
// CHECK | validates latched length; rejects with ch_err+ch_ack
// START | tx_start_en + ch_ack to the granted channel
// BUSY  | forwarding tx_req/tx_data until tx_done (or watchdog)
// GAP   | GAP_CYCLES idle clocks before the next arbitration
module udp_tx_sched #(
  parameter int NUM_CH         = 4,
  parameter int MAX_PAYLOAD    = 1472,
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  gmii_tx_clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [16*NUM_CH-1:0]  ch_byte_num,
  input  logic [48*NUM_CH-1:0]  ch_des_mac,
  input  logic [32*NUM_CH-1:0]  ch_des_ip,
  input  logic [8*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]     ch_ack,
  output logic [NUM_CH-1:0]     ch_rd_en,
  output logic [NUM_CH-1:0]     ch_done,
  output logic [NUM_CH-1:0]     ch_err,
  output logic                  tx_start_en,
  output logic [15:0]           tx_byte_num,
  output logic [47:0]           des_mac,
  output logic [31:0]           des_ip,
  output logic [7:0]            tx_data,
  input  logic                  tx_req,
  input  logic                  tx_done,
  output logic                  busy,
  output logic [2:0]            grant_id
);

  typedef enum logic [2:0] {IDLE, CHECK, START, BUSY, GAP} state_t;

  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_chk_num_ch
    $error("udp_tx_sched: NUM_CH must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_chk_timeout
    $error("udp_tx_sched: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  state_t             state, state_nxt;
  logic [2:0]         rr_ptr;
  logic [2:0]         next_ptr;
  logic [2:0]         sel_id;
  logic [2:0]         cand;
  logic               sel_vld;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_CH-1:0]  grant_oh;
  logic               len_bad;
  logic               tmo_hit;

  // First requesting channel at or after rr_ptr, wrapping.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = 3'((int'(rr_ptr) + k) % NUM_CH);
      if (!sel_vld && |(ch_req & (ONE << cand))) begin
        sel_vld = 1'b1;
        sel_id  = cand;
      end
    end
  end

  assign grant_oh = ONE << grant_id;
  assign next_ptr = 3'((int'(grant_id) + 1) % NUM_CH);
  assign len_bad  = (tx_byte_num == 16'd0) || (tx_byte_num > 16'(MAX_PAYLOAD));
  assign tx_data  = ch_data[8*int'(grant_id) +: 8];
  assign busy     = (state != IDLE);

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Held at zero outside BUSY, so it is clear on every BUSY entry.
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == BUSY) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // tx_done in the same cycle takes priority over the watchdog.
  assign tmo_hit = (state == BUSY) && !tx_done && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      tx_byte_num <= '0;
      des_mac     <= '0;
      des_ip      <= '0;
      gap_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_vld) begin
        grant_id    <= sel_id;
        tx_byte_num <= ch_byte_num[16*int'(sel_id) +: 16];
        des_mac     <= ch_des_mac[48*int'(sel_id) +: 48];
        des_ip      <= ch_des_ip[32*int'(sel_id) +: 32];
      end
      if ((state == CHECK && len_bad) || (state == BUSY && (tx_done || tmo_hit))) begin
        rr_ptr <= next_ptr;
      end
      // Gap timer: preloaded outside GAP, counts down to terminal zero in GAP.
      if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end else begin
        gap_cnt <= GAP_W'(GAP_LOAD);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ch_ack      = '0;
    ch_err      = '0;
    ch_done     = '0;
    ch_rd_en    = '0;
    tx_start_en = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) state_nxt = CHECK;
      end
      CHECK: begin
        if (len_bad) begin
          ch_err    = grant_oh;
          ch_ack    = grant_oh;
          state_nxt = IDLE;
        end else begin
          state_nxt = START;
        end
      end
      START: begin
        tx_start_en = 1'b1;
        ch_ack      = grant_oh;
        state_nxt   = BUSY;
      end
      BUSY: begin
        ch_rd_en = grant_oh & {NUM_CH{tx_req}};
        if (tx_done) begin
          ch_done   = grant_oh;
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (tmo_hit) begin
          ch_err    = grant_oh;
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Testbench for udp_tx_sched. Stimulus pushes expected scheduler events
// (start / reject / done pulses with the latched header) into a queue. A
// monitor pops and compares whenever the DUT pulses any of them.
module tb_udp_tx_sched;
  localparam int NUM_CH = 4;
  localparam int GAP    = 12;

  logic          gmii_tx_clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    ch_req;
  logic [63:0]   ch_byte_num = '0;
  logic [191:0]  ch_des_mac = '0;
  logic [127:0]  ch_des_ip = '0;
  logic [31:0]   ch_data = 32'h3525_1505;
  logic [3:0]    ch_ack, ch_rd_en, ch_done, ch_err;
  logic          tx_start_en;
  logic [15:0]   tx_byte_num;
  logic [47:0]   des_mac;
  logic [31:0]   des_ip;
  logic [7:0]    tx_data;
  logic          tx_req = 1'b0;
  logic          tx_done = 1'b0;
  logic          busy;
  logic [2:0]    grant_id;

  int checks = 0;
  int failures = 0;
  int req_tok[4] = '{default: 0};
  int served[4]  = '{default: 0};

  typedef struct packed {
    logic        start;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [3:0]  done;
    logic [2:0]  grant;
    logic [15:0] len;
    logic [47:0] mac;
    logic [31:0] ip;
  } ev_t;

  ev_t exp_q[$];

  udp_tx_sched #(
    .NUM_CH(NUM_CH), .MAX_PAYLOAD(1472), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(64)
  ) dut (
    .gmii_tx_clk(gmii_tx_clk), .rst(rst), .ch_req(ch_req),
    .ch_byte_num(ch_byte_num), .ch_des_mac(ch_des_mac), .ch_des_ip(ch_des_ip),
    .ch_data(ch_data), .ch_ack(ch_ack), .ch_rd_en(ch_rd_en), .ch_done(ch_done),
    .ch_err(ch_err), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
    .des_mac(des_mac), .des_ip(des_ip), .tx_data(tx_data), .tx_req(tx_req),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id)
  );

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  // Source model: a request stays raised until the scheduler acknowledges it.
  always_comb begin
    ch_req = '0;
    for (int i = 0; i < 4; i++) ch_req[i] = (req_tok[i] != served[i]);
  end

  initial forever begin
    @(posedge gmii_tx_clk);
    #1;
    for (int i = 0; i < 4; i++) if (ch_ack[i]) served[i]++;
  end

  // Scoreboard monitor.
  initial begin
    ev_t act, e;
    forever begin
      @(negedge gmii_tx_clk);
      if (tx_start_en || |ch_ack || |ch_err || |ch_done) begin
        act = '{start: tx_start_en, ack: ch_ack, err: ch_err, done: ch_done,
                grant: grant_id, len: tx_byte_num, mac: des_mac, ip: des_ip};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event t=%0t actual=%h required=none", $time, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL event t=%0t actual=%h required=%h", $time, act, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge gmii_tx_clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int ch);
    logic [3:0] r;
    r = '0;
    r[ch] = 1'b1;
    return r;
  endfunction

  function automatic ev_t mk_ev(input logic s, input logic [3:0] a, input logic [3:0] er,
                                input logic [3:0] d, input int ch, input logic [15:0] len,
                                input logic [47:0] mac, input logic [31:0] ip);
    ev_t r;
    r.start = s; r.ack = a; r.err = er; r.done = d;
    r.grant = 3'(ch); r.len = len; r.mac = mac; r.ip = ip;
    return r;
  endfunction

  task automatic set_ch(input int ch, input logic [15:0] len, input logic [47:0] mac,
                        input logic [31:0] ip);
    ch_byte_num[16*ch +: 16] = len;
    ch_des_mac[48*ch +: 48]  = mac;
    ch_des_ip[32*ch +: 32]   = ip;
  endtask

  task automatic exp_pkt(input int ch, input logic [15:0] len, input logic [47:0] mac,
                         input logic [31:0] ip);
    exp_q.push_back(mk_ev(1'b1, oh(ch), 4'b0, 4'b0, ch, len, mac, ip));
    exp_q.push_back(mk_ev(1'b0, 4'b0, 4'b0, oh(ch), ch, len, mac, ip));
  endtask

  task automatic count_gap(input bit inject);
    int gap;
    gap = 0;
    while (busy && gap < GAP + 20) begin
      if (inject && gap == 3) tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      gap++;
    end
    chk("gap_cycles", gap, GAP);
  endtask

  // UDP transmitter model for one packet on channel ch.
  task automatic serve(input int ch, input int len, input logic [47:0] mac,
                       input bit inject, output int lat);
    int rd, other;
    lat = 0;
    while (!tx_start_en && lat < 40) begin
      tick();
      lat++;
    end
    chk("start_seen", tx_start_en, 1);
    tick();
    if (inject) set_ch(1, 16'd999, 48'hDEAD_BEEF_0001, 32'hC0A8_0063);
    chk("tx_data_mux", tx_data, 8'h05 + 8'(16 * ch));
    rd = 0;
    other = 0;
    for (int k = 0; k < len; k++) begin
      tx_req = 1'b1;
      #1;
      if (ch_rd_en[ch]) rd++;
      if ((ch_rd_en & ~oh(ch)) != 4'b0) other++;
      tick();
    end
    tx_req = 1'b0;
    chk("rd_en_count", rd, len);
    chk("rd_en_other", other, 0);
    chk("len_stable", tx_byte_num, len);
    chk("mac_stable", des_mac, mac);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    count_gap(inject);
  endtask

  task automatic wait_drop(input int ch, input string name);
    int n, st;
    n = 0;
    st = 0;
    while (ch_req[ch] && n < 20) begin
      tick();
      n++;
      if (tx_start_en) st++;
    end
    repeat (3) begin
      tick();
      if (tx_start_en) st++;
    end
    chk({name, "_consumed"}, ch_req[ch], 0);
    chk({name, "_no_start"}, st, 0);
  endtask

  initial begin
    int lat, n, bc;
    int lens[4] = '{10, 30, 1, 1472};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_len", tx_byte_num, 0);
    chk("rst_mac", des_mac, 0);
    chk("rst_ip", des_ip, 0);
    chk("rst_pulses", {tx_start_en, ch_ack, ch_err, ch_done}, 0);
    tx_req = 1'b1;
    #1;
    chk("idle_rd_en", ch_rd_en, 0);
    tx_req = 1'b0;
    tick();

    // All four channels at once: grant order 0,1,2,3.
    for (int i = 0; i < 4; i++) begin
      set_ch(i, 16'(lens[i]), 48'h0200_0000_0010 + 48'(i), 32'hC0A8_0010 + 32'(i));
      exp_pkt(i, 16'(lens[i]), 48'h0200_0000_0010 + 48'(i), 32'hC0A8_0010 + 32'(i));
    end
    for (int i = 0; i < 4; i++) req_tok[i]++;
    for (int i = 0; i < 4; i++) serve(i, lens[i], 48'h0200_0000_0010 + 48'(i), 1'b0, lat);

    // Single request on channel 0, checking start latency.
    set_ch(0, 16'd10, 48'h0200_0000_0001, 32'hC0A8_0002);
    exp_pkt(0, 16'd10, 48'h0200_0000_0001, 32'hC0A8_0002);
    req_tok[0]++;
    serve(0, 10, 48'h0200_0000_0001, 1'b0, lat);
    chk("start_latency", lat, 2);

    // Length limits on channel 2.
    set_ch(2, 16'd0, 48'h0200_0000_0022, 32'hC0A8_0022);
    exp_q.push_back(mk_ev(1'b0, oh(2), oh(2), 4'b0, 2, 16'd0, 48'h0200_0000_0022, 32'hC0A8_0022));
    req_tok[2]++;
    wait_drop(2, "len0");
    set_ch(2, 16'd1473, 48'h0200_0000_0022, 32'hC0A8_0022);
    exp_q.push_back(mk_ev(1'b0, oh(2), oh(2), 4'b0, 2, 16'd1473, 48'h0200_0000_0022, 32'hC0A8_0022));
    req_tok[2]++;
    wait_drop(2, "len1473");
    set_ch(2, 16'd1472, 48'h0200_0000_0022, 32'hC0A8_0022);
    exp_pkt(2, 16'd1472, 48'h0200_0000_0022, 32'hC0A8_0022);
    req_tok[2]++;
    serve(2, 1472, 48'h0200_0000_0022, 1'b0, lat);

    // Channel 1 inputs change during BUSY; stray tx_done in GAP.
    set_ch(1, 16'd20, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0061);
    exp_pkt(1, 16'd20, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0061);
    req_tok[1]++;
    serve(1, 20, 48'h0A0B_0C0D_0E0F, 1'b1, lat);

    // Reset five bytes into a 30-byte packet on channel 3.
    set_ch(3, 16'd30, 48'h0200_0000_0033, 32'hC0A8_0033);
    exp_q.push_back(mk_ev(1'b1, oh(3), 4'b0, 4'b0, 3, 16'd30, 48'h0200_0000_0033, 32'hC0A8_0033));
    req_tok[3]++;
    n = 0;
    while (!tx_start_en && n < 40) begin
      tick();
      n++;
    end
    chk("rst_test_start", tx_start_en, 1);
    tick();
    repeat (5) begin
      tx_req = 1'b1;
      tick();
    end
    tx_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_grant", grant_id, 0);
    chk("midrst_len", tx_byte_num, 0);
    chk("midrst_mac", des_mac, 0);
    chk("midrst_ip", des_ip, 0);
    chk("midrst_pulses", {tx_start_en, ch_ack, ch_err, ch_done, ch_rd_en}, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_done_ignored", busy, 0);
    set_ch(0, 16'd4, 48'h0200_0000_0040, 32'hC0A8_0040);
    exp_pkt(0, 16'd4, 48'h0200_0000_0040, 32'hC0A8_0040);
    exp_pkt(3, 16'd30, 48'h0200_0000_0033, 32'hC0A8_0033);
    req_tok[0]++;
    req_tok[3]++;
    serve(0, 4, 48'h0200_0000_0040, 1'b0, lat);
    serve(3, 30, 48'h0200_0000_0033, 1'b0, lat);

`ifdef UDP_TX_SCHED_TIMEOUT_EN
    // Watchdog: channel 1 never completes, channel 2 is granted next.
    set_ch(1, 16'd8, 48'h0200_0000_0051, 32'hC0A8_0051);
    set_ch(2, 16'd6, 48'h0200_0000_0052, 32'hC0A8_0052);
    exp_q.push_back(mk_ev(1'b1, oh(1), 4'b0, 4'b0, 1, 16'd8, 48'h0200_0000_0051, 32'hC0A8_0051));
    exp_q.push_back(mk_ev(1'b0, 4'b0, oh(1), 4'b0, 1, 16'd8, 48'h0200_0000_0051, 32'hC0A8_0051));
    exp_pkt(2, 16'd6, 48'h0200_0000_0052, 32'hC0A8_0052);
    req_tok[1]++;
    req_tok[2]++;
    n = 0;
    while (!tx_start_en && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_start", tx_start_en, 1);
    tick();
    bc = 1;
    while (!ch_err[1] && bc < 200) begin
      tick();
      bc++;
    end
    chk("tmo_cycle", bc, 64);
    tick();
    count_gap(1'b0);
    serve(2, 6, 48'h0200_0000_0052, 1'b0, lat);
`endif

    repeat (4) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
